i2c_cmd_sequencer: RTL and testbench
====================================

// Module: i2c_cmd_sequencer
// PURPOSE
//  Upstream command stage for I2CInterface. Queues host-issued I2C transactions (slave addr, sub addr, R/W,
//  write byte, read count) and presents them one at a time on the I2CInterface control bus.
//  Generates the PCControl start pulse, waits for completion, and returns ReadData plus NACK/timeout status
//  through a valid/ready response port. Host wire-ins/trigger-outs connect on the other side.
// PARAMETERS
//  DEPTH          4        command FIFO entries (power of 2, >=2)
//  PULSE_CYCLES   10000    FSM_Clk cycles PCControl is held high per transaction (>=1)
//  TIMEOUT_CYCLES 4000000  FSM_Clk cycles in WAIT before timeout error (used only with I2C_SEQ_TIMEOUT_EN)
// PORTS
//  FSM_Clk        in   1   sole clock, rising edge
//  Reset          in   1   synchronous, active-high
//  CmdValid       in   1   host command present
//  CmdReady       out  1   FIFO can accept (count < DEPTH)
//  CmdSlaveAddr   in   7   / CmdSubAddr in 7 / CmdRW in 1 (1=read) / CmdWriteData in 8 / CmdBytesToRead in 8
//  PCControl      out  1   start request to I2CInterface
//  SlaveAddress   out  7   / SubAddress out 7 / ReadWrite out 1 / WriteData out 8 / BytesToRead out 8
//  I2CDone        in   1   one-cycle pulse from I2CInterface at transaction end
//  ACK_bit        in   1   sampled with I2CDone; 1 = slave NACKed
//  ReadData       in   32  read bytes from I2CInterface, valid with I2CDone
//  RspValid       out  1   response held until RspReady
//  RspReady       in   1   host consumed response
//  RspData        out  32  ReadData for reads; 0 for writes and errors
//  RspError       out  2   00 ok, 01 NACK, 10 timeout
//  QueueCount     out  $clog2(DEPTH)+1  FIFO occupancy
//  Busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE; CmdReady=1 the cycle after Reset deasserts.
//  Reset mid-transaction: PCControl drops next edge, queued commands and pending response discarded.
//  FIFO: push when CmdValid&&CmdReady; CmdReady from registered count only. Full + pop same cycle: push
//   not accepted. Non-full push+pop: count unchanged. Pop only in LOAD.
//  FSM: IDLE -(count!=0 && !RspValid)-> LOAD: bus outputs registered from FIFO head, pop, 1 cycle ->
//   PULSE: PCControl=1 for exactly PULSE_CYCLES -> WAIT: PCControl=0; on I2CDone capture ACK_bit/ReadData
//   -> RESP: RspValid=1, RspData/RspError stable; on RspReady -> IDLE (RspValid=0 next edge).
//  Bus outputs (SlaveAddress..BytesToRead) hold last command value from LOAD until next LOAD.
//  I2CDone outside WAIT ignored (no state change, no response).
//  Latency: first queued cmd -> PCControl rise = 2 cycles from push; I2CDone -> RspValid = 1 cycle.
//  ACK_bit=1 at done: RspError=01, RspData=0. Read with BytesToRead=0 passed through unchanged.
//  One response buffer: next command not started until current response consumed (back-pressure).
// CONFIGURATION
//  I2C_SEQ_TIMEOUT_EN defined: counter runs in WAIT; reaching TIMEOUT_CYCLES without I2CDone -> RESP with
//   RspError=10, RspData=0; late I2CDone then ignored. Undefined: WAIT has no exit except I2CDone/Reset,
//   encoding 10 never produced, no counter synthesised.
// STRUCTURE
//  i2c_seq_pkg.vh: state encodings (IDLE,LOAD,PULSE,WAIT,RESP), RspError codes, command word width (31 b:
//   7+7+1+8+8) and field offsets.
//  Sub-module i2c_cmd_fifo: synchronous DEPTH x 31 FIFO, push/pop/full/empty/count. Top holds FSM,
//   pulse/timeout counters, response register.
// TESTING
//  1 Write: push {0x19,0x20,W,0xAA} -> PCControl high exactly PULSE_CYCLES; outputs 0x19/0x20/0/0xAA;
//    I2CDone,ACK_bit=0 -> RspValid, RspError=00, RspData=0.
//  2 Read: push {0x1E,0x03,R,BytesToRead=2}; I2CDone with ReadData=0x0000_1234 -> RspData=0x1234, err 00.
//  3 Fill: push 5 cmds with PULSE stalled -> CmdReady=0 at QueueCount=4, 5th held; drains in order
//    after responses, each only after RspReady.
//  4 NACK: I2CDone with ACK_bit=1 -> RspError=01, RspData=0; stray I2CDone in IDLE -> no response.
//  5 Timeout (I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100): no I2CDone -> RspError=10 at cycle 100 of WAIT;
//    without macro -> still WAIT after 1000 cycles.
//  6 Reset during PULSE with 2 queued -> PCControl=0, QueueCount=0, RspValid=0, Busy=0 next edge.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for i2c_cmd_sequencer: FSM states, response codes and the
// 31-bit command word layout (slave:7, sub:7, rw:1, wdata:8, nbytes:8).
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_NACK    = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_err_e;

  localparam int CMD_W     = 31;
  localparam int OFS_BYTES = 0;
  localparam int OFS_WDATA = 8;
  localparam int OFS_RW    = 16;
  localparam int OFS_SUB   = 17;
  localparam int OFS_SLAVE = 24;

  // Field order matches the offsets above, so a word casts directly to cmd_t.
  typedef struct packed {
    logic [6:0] slave_addr;
    logic [6:0] sub_addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] nbytes;
  } cmd_t;

  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [6:0] slave_addr,
    input logic [6:0] sub_addr,
    input logic       rw,
    input logic [7:0] wdata,
    input logic [7:0] nbytes
  );
    logic [CMD_W-1:0] word;
    word                 = '0;
    word[OFS_SLAVE +: 7] = slave_addr;
    word[OFS_SUB   +: 7] = sub_addr;
    word[OFS_RW]         = rw;
    word[OFS_WDATA +: 8] = wdata;
    word[OFS_BYTES +: 8] = nbytes;
    return word;
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous DEPTH x CMD_W command FIFO with occupancy count; push is refused
// while full even if a pop happens in the same cycle.
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [CMD_W-1:0]         data_i,
  input  logic                     pop_i,
  output logic [CMD_W-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands and runs them one at a time on the I2CInterface bus,
// returning ReadData/status via valid/ready. Define I2C_SEQ_TIMEOUT_EN for the WAIT timeout.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int PULSE_CYCLES   = 10000,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic                   FSM_Clk,
  input  logic                   Reset,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic [6:0]             CmdSlaveAddr,
  input  logic [6:0]             CmdSubAddr,
  input  logic                   CmdRW,
  input  logic [7:0]             CmdWriteData,
  input  logic [7:0]             CmdBytesToRead,
  output logic                   PCControl,
  output logic [6:0]             SlaveAddress,
  output logic [6:0]             SubAddress,
  output logic                   ReadWrite,
  output logic [7:0]             WriteData,
  output logic [7:0]             BytesToRead,
  input  logic                   I2CDone,
  input  logic                   ACK_bit,
  input  logic [31:0]            ReadData,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic [31:0]            RspData,
  output logic [1:0]             RspError,
  output logic [$clog2(DEPTH):0] QueueCount,
  output logic                   Busy
);

  // One counter serves both the start pulse and the WAIT timeout, sized for the longer.
  localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             bus_q, bus_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  rsp_err_e         rsp_err_q, rsp_err_d;
  logic             rdy_en_q;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] cmd_word, head_word;

  assign cmd_word = pack_cmd(CmdSlaveAddr, CmdSubAddr, CmdRW, CmdWriteData, CmdBytesToRead);
  assign CmdReady = rdy_en_q && !fifo_full;
  assign push     = CmdValid && CmdReady;

  i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (FSM_Clk),
    .rst_i   (Reset),
    .push_i  (push),
    .data_i  (cmd_word),
    .pop_i   (pop),
    .data_o  (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (QueueCount)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_d      = bus_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    pop        = 1'b0;
    unique case (state_q)
      // The single response buffer is free whenever we are back in IDLE.
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        bus_d   = cmd_t'(head_word);
        pop     = 1'b1;
        cnt_d   = '0;
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (I2CDone) begin
          rsp_err_d  = ACK_bit ? RSP_NACK : RSP_OK;
          rsp_data_d = (!ACK_bit && bus_q.rw) ? ReadData : '0;
          state_d    = ST_RESP;
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          rsp_err_d  = RSP_TIMEOUT;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: if (RspReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FSM_Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bus_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= RSP_OK;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_q      <= bus_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign PCControl    = (state_q == ST_PULSE);
  assign RspValid     = (state_q == ST_RESP);
  assign Busy         = (state_q != ST_IDLE);
  assign RspData      = rsp_data_q;
  assign RspError     = rsp_err_q;
  assign SlaveAddress = bus_q.slave_addr;
  assign SubAddress   = bus_q.sub_addr;
  assign ReadWrite    = bus_q.rw;
  assign WriteData    = bus_q.wdata;
  assign BytesToRead  = bus_q.nbytes;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: directed vector table, back-pressure,
// timeout and reset sequences, then random transactions against a transaction-level model.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int PULSE = 6;
  localparam int TMO   = 100;

  typedef struct {
    logic [6:0] sa;
    logic [6:0] suba;
    logic       rw;
    logic [7:0] wd;
    logic [7:0] nb;
  } tcmd_t;

  typedef struct {
    tcmd_t       c;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  logic        FSM_Clk, Reset, CmdValid, CmdReady, CmdRW;
  logic [6:0]  CmdSlaveAddr, CmdSubAddr, SlaveAddress, SubAddress;
  logic [7:0]  CmdWriteData, CmdBytesToRead, WriteData, BytesToRead;
  logic        PCControl, ReadWrite, I2CDone, ACK_bit, RspValid, RspReady, Busy;
  logic [31:0] ReadData, RspData;
  logic [1:0]  RspError;
  logic [$clog2(DEPTH):0] QueueCount;

  int    n_chk = 0;
  int    n_err = 0;
  tcmd_t model_q[$];
  int    pulse_lens[$];
  int    hi_run = 0;

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
    .FSM_Clk(FSM_Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdSlaveAddr(CmdSlaveAddr), .CmdSubAddr(CmdSubAddr), .CmdRW(CmdRW),
    .CmdWriteData(CmdWriteData), .CmdBytesToRead(CmdBytesToRead), .PCControl(PCControl),
    .SlaveAddress(SlaveAddress), .SubAddress(SubAddress), .ReadWrite(ReadWrite),
    .WriteData(WriteData), .BytesToRead(BytesToRead), .I2CDone(I2CDone), .ACK_bit(ACK_bit),
    .ReadData(ReadData), .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .RspError(RspError), .QueueCount(QueueCount), .Busy(Busy)
  );

  initial begin
    FSM_Clk = 1'b0;
    forever #5 FSM_Clk = ~FSM_Clk;
  end

  // Record the length of every PCControl high run.
  always @(negedge FSM_Clk) begin
    if (PCControl) hi_run = hi_run + 1;
    else if (hi_run != 0) begin
      pulse_lens.push_back(hi_run);
      hi_run = 0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge FSM_Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tcmd_t mk_cmd(input logic [6:0] sa, input logic [6:0] suba, input logic rw,
                                   input logic [7:0] wd, input logic [7:0] nb);
    tcmd_t c;
    c.sa = sa; c.suba = suba; c.rw = rw; c.wd = wd; c.nb = nb;
    return c;
  endfunction

  function automatic tcmd_t rand_cmd();
    return mk_cmd(7'($urandom), 7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
  endfunction

  // Response rule: NACK wins with zero data; otherwise reads return ReadData, writes return 0.
  task automatic predict(input tcmd_t c, input logic ack, input logic [31:0] rd,
                         output logic [31:0] d, output logic [1:0] e);
    if (ack) begin
      d = 32'd0; e = 2'b01;
    end else begin
      e = 2'b00;
      d = c.rw ? rd : 32'd0;
    end
  endtask

  task automatic drive_cmd(input tcmd_t c);
    CmdSlaveAddr = c.sa; CmdSubAddr = c.suba; CmdRW = c.rw;
    CmdWriteData = c.wd; CmdBytesToRead = c.nb;
  endtask

  task automatic push_cmd(input tcmd_t c);
    int n;
    drive_cmd(c);
    CmdValid = 1'b1;
    n = 0;
    while (!CmdReady && n < 64) begin tick(); n++; end
    check("push_ready", 32'(CmdReady), 32'd1);
    tick();
    CmdValid = 1'b0;
    model_q.push_back(c);
  endtask

  task automatic check_pulse();
    int pl;
    pl = 0;
    if (pulse_lens.size() != 0) pl = pulse_lens.pop_front();
    check("pulse_len", pl, PULSE);
  endtask

  task automatic consume_rsp(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rsp_hold", 32'(RspValid), 32'd1);
      check("no_start_during_rsp", 32'(PCControl), 32'd0);
    end
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    check("rsp_clear", 32'(RspValid), 32'd0);
  endtask

  task automatic wait_start(input tcmd_t c, input int exp_lat);
    int lat, n;
    lat = 0;
    while (!PCControl && lat < 64) begin tick(); lat++; end
    check("pc_rise", 32'(PCControl), 32'd1);
    if (exp_lat >= 0) check("start_latency", lat, exp_lat);
    check("slave_addr", 32'(SlaveAddress), 32'(c.sa));
    check("sub_addr", 32'(SubAddress), 32'(c.suba));
    check("read_write", 32'(ReadWrite), 32'(c.rw));
    check("write_data", 32'(WriteData), 32'(c.wd));
    check("bytes_to_read", 32'(BytesToRead), 32'(c.nb));
    n = 0;
    while (PCControl && n < PULSE + 64) begin tick(); n++; end
    check("pc_fall", 32'(PCControl), 32'd0);
  endtask

  task automatic run_txn(input tcmd_t c, input logic ack, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic [1:0] exp_err,
                         input int exp_lat, input int wait_dly, input int hold, input bit consume);
    wait_start(c, exp_lat);
    for (int i = 0; i < wait_dly; i++) tick();
    check("wait_busy", 32'(Busy), 32'd1);
    check("wait_no_rsp", 32'(RspValid), 32'd0);
    I2CDone = 1'b1; ACK_bit = ack; ReadData = rdata;
    tick();
    I2CDone = 1'b0; ACK_bit = 1'b0; ReadData = $urandom();
    check("rsp_valid", 32'(RspValid), 32'd1);
    check("rsp_data", RspData, exp_data);
    check("rsp_error", 32'(RspError), 32'(exp_err));
    check_pulse();
    if (consume) consume_rsp(hold);
  endtask

  initial begin
    vec_t        vecs[5];
    tcmd_t       c, f;
    logic        ack;
    logic [31:0] rd, ed;
    logic [1:0]  ee;
    int          n, k;

    vecs[0] = '{mk_cmd(7'h19, 7'h20, 1'b0, 8'hAA, 8'h00), 1'b0, 32'hDEAD_BEEF, 32'h0,         2'b00};
    vecs[1] = '{mk_cmd(7'h1E, 7'h03, 1'b1, 8'h00, 8'h02), 1'b0, 32'h0000_1234, 32'h0000_1234, 2'b00};
    vecs[2] = '{mk_cmd(7'h50, 7'h11, 1'b1, 8'h00, 8'h04), 1'b1, 32'hCAFE_F00D, 32'h0,         2'b01};
    vecs[3] = '{mk_cmd(7'h7F, 7'h7F, 1'b1, 8'hFF, 8'h00), 1'b0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 2'b00};
    vecs[4] = '{mk_cmd(7'h00, 7'h00, 1'b0, 8'h55, 8'hFF), 1'b1, 32'h0000_0001, 32'h0,         2'b01};

    Reset = 1'b1; CmdValid = 1'b0; I2CDone = 1'b0; ACK_bit = 1'b0; RspReady = 1'b0;
    ReadData = 32'd0;
    drive_cmd(mk_cmd(7'h0, 7'h0, 1'b0, 8'h0, 8'h0));

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", 32'(CmdReady), 32'd0);
    check("rst_pc", 32'(PCControl), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_rsp_valid", 32'(RspValid), 32'd0);
    check("rst_qcount", 32'(QueueCount), 32'd0);
    check("rst_slave", 32'(SlaveAddress), 32'd0);
    check("rst_rsp_data", RspData, 32'd0);
    Reset = 1'b0;
    tick();
    check("ready_after_rst", 32'(CmdReady), 32'd1);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      push_cmd(vecs[i].c);
      c = model_q.pop_front();
      run_txn(c, vecs[i].ack, vecs[i].rdata, vecs[i].exp_data, vecs[i].exp_err, 2, i % 3, i % 2, 1'b1);
    end

    // Stray I2CDone while idle
    I2CDone = 1'b1; ACK_bit = 1'b1;
    tick();
    I2CDone = 1'b0; ACK_bit = 1'b0;
    check("stray_no_rsp", 32'(RspValid), 32'd0);
    check("stray_idle", 32'(Busy), 32'd0);
    tick();
    check("stray_no_rsp2", 32'(RspValid), 32'd0);

    // Back-pressure: hold a response, fill the FIFO, keep a fifth command waiting
    push_cmd(rand_cmd());
    c = model_q.pop_front();
    rd = $urandom();
    predict(c, 1'b0, rd, ed, ee);
    run_txn(c, 1'b0, rd, ed, ee, 2, 1, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_ready", 32'(CmdReady), 32'd1);
      push_cmd(rand_cmd());
      check("fill_count", 32'(QueueCount), 32'(i + 1));
    end
    check("full_not_ready", 32'(CmdReady), 32'd0);
    f = rand_cmd();
    drive_cmd(f);
    CmdValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_count", 32'(QueueCount), 32'(DEPTH));
      check("held_not_ready", 32'(CmdReady), 32'd0);
      check("held_rsp", 32'(RspValid), 32'd1);
    end
    consume_rsp(0);
    n = 0;
    while (!CmdReady && n < 64) begin tick(); n++; end
    check("held_accepted", 32'(CmdReady), 32'd1);
    tick();
    CmdValid = 1'b0;
    model_q.push_back(f);
    check("refill_count", 32'(QueueCount), 32'(DEPTH));
    while (model_q.size() != 0) begin
      c = model_q.pop_front();
      ack = ($urandom_range(0, 3) == 0);
      rd = $urandom();
      predict(c, ack, rd, ed, ee);
      run_txn(c, ack, rd, ed, ee, -1, $urandom_range(0, 3), $urandom_range(1, 4), 1'b1);
    end

    // Random transactions, 1-3 queued at a time
    for (int it = 0; it < 20; it++) begin
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) push_cmd(rand_cmd());
      while (model_q.size() != 0) begin
        c = model_q.pop_front();
        ack = ($urandom_range(0, 3) == 0);
        rd = $urandom();
        predict(c, ack, rd, ed, ee);
        run_txn(c, ack, rd, ed, ee, -1, $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
      end
      check("rand_idle", 32'(Busy), 32'd0);
    end

    // No completion from the I2C side
    push_cmd(rand_cmd());
    c = model_q.pop_front();
    wait_start(c, 2);
`ifdef I2C_SEQ_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) tick();
    check("tmo_not_yet", 32'(RspValid), 32'd0);
    tick();
    check("tmo_rsp_valid", 32'(RspValid), 32'd1);
    check("tmo_error", 32'(RspError), 32'd2);
    check("tmo_data", RspData, 32'd0);
    I2CDone = 1'b1; ACK_bit = 1'b0; ReadData = 32'h1234_5678;
    tick();
    I2CDone = 1'b0;
    check("late_done_error", 32'(RspError), 32'd2);
    check("late_done_data", RspData, 32'd0);
`else
    for (int i = 0; i < 1000; i++) tick();
    check("no_tmo_busy", 32'(Busy), 32'd1);
    check("no_tmo_rsp", 32'(RspValid), 32'd0);
    check("no_tmo_pc", 32'(PCControl), 32'd0);
    rd = $urandom();
    I2CDone = 1'b1; ACK_bit = 1'b0; ReadData = rd;
    tick();
    I2CDone = 1'b0;
    predict(c, 1'b0, rd, ed, ee);
    check("no_tmo_rsp_valid", 32'(RspValid), 32'd1);
    check("no_tmo_data", RspData, ed);
    check("no_tmo_error", 32'(RspError), 32'(ee));
`endif
    check_pulse();
    consume_rsp(1);

    // Reset during PULSE with two commands queued
    for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
    check("pre_rst_pc", 32'(PCControl), 32'd1);
    check("pre_rst_count", 32'(QueueCount), 32'd2);
    Reset = 1'b1;
    tick();
    check("mid_rst_pc", 32'(PCControl), 32'd0);
    check("mid_rst_count", 32'(QueueCount), 32'd0);
    check("mid_rst_rsp", 32'(RspValid), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(CmdReady), 32'd1);
    check("post_rst_bus", 32'(SlaveAddress), 32'd0);
    tick();
    check("post_rst_idle", 32'(Busy), 32'd0);
    model_q.delete();
    pulse_lens.delete();

    // Recovery after reset
    push_cmd(vecs[1].c);
    c = model_q.pop_front();
    run_txn(c, vecs[1].ack, vecs[1].rdata, vecs[1].exp_data, vecs[1].exp_err, 2, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
